// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: default geometry, FSM encodings
// and the bytes-per-word derivation used by the loader and its assembler.
package prog_loader_pkg;

    localparam int DEF_INST_WIDTH   = 16;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_NUM_MEM_ADDR = 256;

    localparam logic [1:0] LD_LOAD  = 2'b00;
    localparam logic [1:0] LD_WRITE = 2'b01;
    localparam logic [1:0] LD_DONE  = 2'b10;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/prog_word_assembler.sv
// Shifts accepted bytes MSB-first into an instruction word and flags the byte
// that completes it; surplus high bits fall off the top of the register.
module prog_word_assembler
    import prog_loader_pkg::*;
#(
    parameter int INST_WIDTH = DEF_INST_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  accept,
    input  logic [7:0]            Byte_In,
    output logic [INST_WIDTH-1:0] word,
    output logic                  word_complete
);

    localparam int BPW   = bytes_per_word(INST_WIDTH);
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0] byte_cnt;
    logic             last_byte;

    assign last_byte     = (byte_cnt == CNT_W'(BPW - 1));
    assign word_complete = accept && last_byte;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            word     <= INST_WIDTH'({word, Byte_In});
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: fills the instruction RAM one word per address
// and keeps the processor in reset until the final word has been written.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INST_WIDTH   = DEF_INST_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int NUM_MEM_ADDR = DEF_NUM_MEM_ADDR
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [7:0]            Byte_In,
    input  logic                  Byte_Valid,
    output logic                  Byte_Ready,
    input  logic                  Start,
    output logic                  Ram_Inst_Write,
    output logic [ADDR_WIDTH-1:0] Inst_Addr,
    output logic [INST_WIDTH-1:0] Ram_Inst_In,
    output logic                  Cpu_Reset,
    output logic                  Load_Done
);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [INST_WIDTH-1:0] word;
    logic                  accept;
    logic                  word_complete;
    logic                  last_addr;

    assign accept    = Byte_Valid && Byte_Ready;
    assign last_addr = (addr == ADDR_WIDTH'(NUM_MEM_ADDR - 1));

    prog_word_assembler #(
        .INST_WIDTH(INST_WIDTH)
    ) u_assembler (
        .Clk          (Clk),
        .Reset        (Reset),
        .accept       (accept),
        .Byte_In      (Byte_In),
        .word         (word),
        .word_complete(word_complete)
    );

    always_comb begin
        next_state = state;
        case (state)
            LD_LOAD:  if (word_complete) next_state = LD_WRITE;
            LD_WRITE: next_state = last_addr ? LD_DONE : LD_LOAD;
            LD_DONE:  if (Start) next_state = LD_LOAD;
            default:  next_state = LD_LOAD;
        endcase
    end

    // Every status output is a flop decoded from the next state, so each one
    // changes on the same edge as the state it describes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state          <= LD_LOAD;
            Byte_Ready     <= 1'b0;
            Ram_Inst_Write <= 1'b0;
            Cpu_Reset      <= 1'b1;
            Load_Done      <= 1'b0;
        end else begin
            state          <= next_state;
            Byte_Ready     <= (next_state == LD_LOAD);
            Ram_Inst_Write <= (next_state == LD_WRITE);
            Cpu_Reset      <= (next_state != LD_DONE);
            Load_Done      <= (next_state == LD_DONE);
        end
    end

    // The address stops at the last word instead of wrapping; only a reload rewinds it.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr <= '0;
        end else if (state == LD_WRITE && !last_addr) begin
            addr <= addr + 1'b1;
        end else if (state == LD_DONE && Start) begin
            addr <= '0;
        end
    end

    assign Inst_Addr   = addr;
    assign Ram_Inst_In = word;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Upstream program loader for PROCESSOR. Accepts a byte stream over a valid/ready handshake and assembles bytes MSB-first into instruction words. It writes each word into the processor's instruction RAM via the Ram_Inst_Write / Inst_Addr / Ram_Inst_In port set, and holds the processor in reset until every address has been written. This is the hardware equivalent of the bench's file-driven RAM fill.

Parameters:
INST_WIDTH, 16, instruction word width in bits (from shared parameters.v).
ADDR_WIDTH, 8, instruction RAM address width.
NUM_MEM_ADDR, 256, number of words to load (≤ 2^ADDR_WIDTH, ≥ 1).
BYTES_PER_WORD, ceil(INST_WIDTH/8), derived; not overridable.

Ports:
Clk  in  1  system clock; all state changes on rising edge.
Reset  in  1  asynchronous, active-low reset.
Byte_In  in  8  program byte.
Byte_Valid  in  1  Byte_In holds a valid byte.
Byte_Ready  out  1  loader can accept a byte this cycle.
Start  in  1  single-cycle pulse; requests a reload (honoured only in DONE).
Ram_Inst_Write  out  1  instruction RAM write strobe.
Inst_Addr  out  ADDR_WIDTH  instruction RAM write address.
Ram_Inst_In  out  INST_WIDTH  instruction RAM write data.
Cpu_Reset  out  1  active-high reset to PROCESSOR.
Load_Done  out  1  all NUM_MEM_ADDR words written.

Behaviour:
- Reset asserted (async): state=LOAD, addr=0, byte_cnt=0, word reg=0. Outputs: Ram_Inst_Write=0, Inst_Addr=0, Ram_Inst_In=0, Cpu_Reset=1, Load_Done=0, Byte_Ready=0. Byte_Ready rises on the first clock after Reset deasserts.
- All outputs are registered; none is combinational from inputs.
- Handshake: a byte transfers on a rising edge where Byte_Valid && Byte_Ready. Byte_Valid with Byte_Ready=0 is ignored; the upstream holds the byte. Gaps in Byte_Valid are legal.
- LOAD: Byte_Ready=1, Ram_Inst_Write=0, Cpu_Reset=1.
  - Each accepted byte shifts in: word = {word << 8 | Byte_In}, truncated to INST_WIDTH.
  - When INST_WIDTH is not a multiple of 8, the upper unused bits of the first byte are discarded.
  - byte_cnt increments per accepted byte. On the byte where byte_cnt == BYTES_PER_WORD-1: byte_cnt→0, state→WRITE.
- WRITE (exactly one cycle): Ram_Inst_Write=1, Inst_Addr=addr, Ram_Inst_In=assembled word, Byte_Ready=0.
  - Inst_Addr and Ram_Inst_In stay stable for the whole strobe cycle.
  - Next state: if addr == NUM_MEM_ADDR-1, go to DONE; else addr+1 and back to LOAD.
- DONE: Ram_Inst_Write=0, Byte_Ready=0, Cpu_Reset=0, Load_Done=1. Inst_Addr and Ram_Inst_In hold the last written values.
- Start in DONE: next edge → LOAD with addr=0, byte_cnt=0, Load_Done=0, Cpu_Reset=1.
- Start in LOAD or WRITE: ignored; no restart, no effect on the partial word.
- Throughput: minimum BYTES_PER_WORD+1 cycles per word. Total minimum load time: NUM_MEM_ADDR*(BYTES_PER_WORD+1) cycles.
- Address wrap: addr never exceeds NUM_MEM_ADDR-1. With NUM_MEM_ADDR == 2^ADDR_WIDTH, the last write is at all-ones and no wrap to 0 occurs.
- Reset mid-load (any state): immediate return to reset values. The partial word is discarded and Ram_Inst_Write drops asynchronously. Already-written RAM words are not cleared; the next load overwrites them.
- Cpu_Reset never deasserts before the final WRITE cycle has completed.

Decomposition:
- INST_WIDTH, ADDR_WIDTH and NUM_MEM_ADDR come from the shared parameters.v header.
- Add to that header: the state encodings LD_LOAD, LD_WRITE, LD_DONE (2-bit localparams) and the BYTES_PER_WORD derivation.
- One sub-module: prog_word_assembler. It contains the byte shift register plus byte_cnt, takes Clk/Reset/accept/Byte_In, and outputs word and word_complete.
- prog_loader keeps the FSM, the address counter and the RAM/CPU outputs.

Test Plan:
- Basic load (INST_WIDTH=16, NUM_MEM_ADDR=4), bytes 12 34 56 78 9A BC DE F0 back-to-back → four one-cycle writes: addr0=0x1234, 1=0x5678, 2=0x9ABC, 3=0xDEF0, each 3 cycles apart. Cpu_Reset falls and Load_Done rises the cycle after the addr3 write.
- Backpressure: Byte_Valid held high continuously → Byte_Ready=0 in each WRITE cycle. No byte is lost or duplicated, and RAM contents match the stream exactly.
- Sparse valid: random 0–5 cycle gaps between bytes → same four words and addresses; Ram_Inst_Write only ever one cycle wide.
- Width 12 (INST_WIDTH=12), bytes AB CD → addr0=0xBCD.
- Reset mid-word: after byte 0x12, assert Reset for 2 cycles, then send 56 78… → addr0=0x5678 with no write of 0x12xx. Cpu_Reset stays 1 throughout.
- Reload: in DONE, pulse Start → Load_Done=0 and Cpu_Reset=1 next cycle; a new stream rewrites from addr0. A Start pulsed during LOAD has no effect.
